// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared FSM state type and 2-input gate truth vectors
package gate_tt_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Bit i is the expected gate output for input vector i ({a,b} == i).
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_tt_settle_timer.sv
// rtl/gate_tt_settle_timer.sv - loadable down-counter; expire is high while the count is 0
module gate_tt_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// rtl/gate_tt_checker.sv - walks all input combinations of a gate DUT and checks dut_y against EXPECT
// Define GATE_TT_FAILVEC_EN to build the per-combination fail_vec bitmap; otherwise fail_vec is 0.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int                      N_IN   = 2,
  parameter int                      SETTLE = 1,
  parameter logic [(2**N_IN)-1:0]    EXPECT = TT_NAND
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dut_y,
  output logic [N_IN-1:0]        dut_a,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [(2**N_IN)-1:0]   fail_vec
);

  localparam int                NCOMB    = 2**N_IN;
  localparam int                TW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0]   LAST_IDX = N_IN'(NCOMB - 1);
  localparam logic [N_IN-1:0]   IDX_ONE  = N_IN'(1);
  localparam logic [N_IN:0]     ERR_ONE  = (N_IN + 1)'(1);
  localparam logic [TW-1:0]     LOAD_VAL = TW'(SETTLE - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N_IN-1:0] r_idx;
  logic [N_IN-1:0] w_idx_nxt;
  logic [N_IN:0]   r_err;
  logic [N_IN:0]   w_err_nxt;
  logic            w_load;
  logic            w_expire;
  logic            w_accept;
  logic            w_miss;
  logic            w_exp_bit;

  gate_tt_settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (LOAD_VAL),
    .expire   (w_expire)
  );

  assign w_exp_bit = EXPECT[r_idx];
  // Case inequality so an X or Z on dut_y is judged a mismatch rather than silently passing.
  assign w_miss    = (r_state == S_CHECK) && (dut_y !== w_exp_bit);
  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_SETTLE;
          w_idx_nxt   = '0;
          w_err_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      S_SETTLE: begin
        if (w_expire) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_miss) w_err_nxt = r_err + ERR_ONE;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_ONE;
          w_state_nxt = S_SETTLE;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef GATE_TT_FAILVEC_EN
  logic [NCOMB-1:0] r_fail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fail <= '0;
    end else if (w_accept) begin
      r_fail <= '0;
    end else if (w_miss) begin
      r_fail[r_idx] <= 1'b1;
    end
  end

  assign fail_vec = r_fail;
`else
  assign fail_vec = '0;
`endif

  assign dut_a     = r_idx;
  assign busy      = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err == '0);
  assign err_count = r_err;

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb/tb_gate_tt_checker.sv - bench for gate_tt_checker with NAND, stuck-at-0, wrong-table and slow-settle instances
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

`ifdef GATE_TT_FAILVEC_EN
  localparam bit FV_ON = 1'b1;
`else
  localparam bit FV_ON = 1'b0;
`endif

  typedef struct {
    string      name;
    int         inst;
    int         cycles;
    logic [2:0] err;
    logic       pass;
    logic [3:0] fv;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] start_v;
  wire  [3:0] busy_w;
  wire  [3:0] done_w;
  wire  [3:0] pass_w;
  wire  [1:0] a_w  [4];
  wire  [2:0] err_w[4];
  wire  [3:0] fv_w [4];
  wire  [3:0] y_w;

  int   n_total;
  int   n_pass;
  vec_t tbl[4];
  vec_t sb[$];

  // NAND reference DUTs, plus one output stuck at 0
  assign y_w[0] = ~(a_w[0][1] & a_w[0][0]);
  assign y_w[1] = 1'b0;
  assign y_w[2] = ~(a_w[2][1] & a_w[2][0]);
  assign y_w[3] = ~(a_w[3][1] & a_w[3][0]);

  gate_tt_checker #(.N_IN(2), .SETTLE(1), .EXPECT(TT_NAND)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_y(y_w[0]), .dut_a(a_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]), .fail_vec(fv_w[0]));
  gate_tt_checker #(.N_IN(2), .SETTLE(1), .EXPECT(TT_NAND)) u_stuck (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_y(y_w[1]), .dut_a(a_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]), .fail_vec(fv_w[1]));
  gate_tt_checker #(.N_IN(2), .SETTLE(1), .EXPECT(TT_AND)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_y(y_w[2]), .dut_a(a_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]), .fail_vec(fv_w[2]));
  gate_tt_checker #(.N_IN(2), .SETTLE(3), .EXPECT(TT_NAND)) u_slow (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .dut_y(y_w[3]), .dut_a(a_w[3]),
    .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_count(err_w[3]), .fail_vec(fv_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic chk_idle(input string tag, input int i);
    chk({tag, "_dut_a"}, int'(a_w[i]), 0);
    chk({tag, "_busy"},  int'(busy_w[i]), 0);
    chk({tag, "_done"},  int'(done_w[i]), 0);
    chk({tag, "_pass"},  int'(pass_w[i]), 0);
    chk({tag, "_err"},   int'(err_w[i]), 0);
    chk({tag, "_fv"},    int'(fv_w[i]), 0);
  endtask

  // One full run; restart_at >= 0 pulses start again that many cycles after the accept.
  task automatic run(input vec_t v, input int restart_at);
    int   i;
    int   k;
    int   bad;
    int   per;
    int   exp_a;
    vec_t e;
    i   = v.inst;
    per = v.cycles / 4;
    sb.push_back(v);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    k   = 0;
    bad = 0;
    chk({v.name, "_clr"}, int'({done_w[i], pass_w[i], err_w[i], fv_w[i]}), 0);
    while (done_w[i] !== 1'b1 && k < 400) begin
      exp_a = k / per;
      if (int'(a_w[i]) != exp_a || busy_w[i] !== 1'b1) bad++;
      start_v[i] = (k == restart_at);
      @(negedge clk);
      k++;
    end
    start_v[i] = 1'b0;
    e = sb.pop_front();
    chk({e.name, "_latency"}, k, e.cycles);
    chk({e.name, "_seq"},     bad, 0);
    chk({e.name, "_busy"},    int'(busy_w[i]), 0);
    chk({e.name, "_last_a"},  int'(a_w[i]), 3);
    chk({e.name, "_err"},     int'(err_w[i]), int'(e.err));
    chk({e.name, "_pass"},    int'(pass_w[i]), int'(e.pass));
    chk({e.name, "_fv"},      int'(fv_w[i]), FV_ON ? int'(e.fv) : 0);
    repeat (3) @(negedge clk);
    chk({e.name, "_hold"},    int'({done_w[i], err_w[i]}), int'({1'b1, e.err}));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    tbl[0] = '{name: "nand",    inst: 0, cycles: 8,  err: 3'd0, pass: 1'b1, fv: 4'b0000};
    tbl[1] = '{name: "stuck0",  inst: 1, cycles: 8,  err: 3'd3, pass: 1'b0, fv: 4'b0111};
    tbl[2] = '{name: "and_tt",  inst: 2, cycles: 8,  err: 3'd4, pass: 1'b0, fv: 4'b1111};
    tbl[3] = '{name: "settle3", inst: 3, cycles: 16, err: 3'd0, pass: 1'b1, fv: 4'b0000};

    start_v = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle("reset", i);
    rst_n = 1'b1;

    for (int j = 0; j < 4; j++) run(tbl[j], -1);

    // Rerun from DONE must clear the previous nonzero result at accept.
    run(tbl[1], -1);

    // start while busy is ignored
    run(tbl[0], 3);

    // Reset five cycles into a run aborts it, then a fresh run is complete and correct.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("midreset", 0);
    run(tbl[0], -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
